// File: rtl/fifo_wr_ptr_sync_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_ptr_sync_pkg
// Shared FIFO helpers used by both the write- and read-side pointer blocks:
// default pointer width / synchronizer depth, and Gray encode/decode on the
// widest legal pointer width. Callers zero-extend narrower pointers; leading
// zero bits encode and decode to zero, so the low bits stay exact.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package fifo_wr_ptr_sync_pkg;

  localparam int PTR_MAX_W      = 8;
  localparam int DEF_PTR_WIDTH  = 4;
  localparam int DEF_NUM_STAGES = 2;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray decode: MSB passes through, each lower bit folds in the bit above.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Plain multi-flop synchronizer chain, no logic between stages. Intended for
// Gray-coded buses where at most one bit changes per source update.
// Ports:
//   i_clk   - destination-domain clock
//   i_rst_n - asynchronous active-low reset, clears every stage
//   i_d     - asynchronous input bus (WIDTH bits)
//   o_q     - last stage of the chain (WIDTH bits)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module bit_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_wr_ptr_sync.sv
// ---------------------------------------------------------------------------
// fifo_wr_ptr_sync
// Write-domain pointer helper for an async FIFO: registers a Gray copy of the
// local write pointer, synchronizes the read pointer Gray code into this
// domain, decodes it, and produces a registered fill estimate with an
// almost-full flag and a pulse whenever the synchronized read pointer moves.
// The full compare itself lives in the write-pointer block.
// Ports:
//   CLK             - write-domain clock
//   RST             - asynchronous active-low reset
//   wptr            - local binary write pointer
//   rptr_gray_async - Gray read pointer from the read domain (asynchronous)
//   wptr_conv       - registered Gray copy of wptr
//   rptr_conv       - synchronized read pointer, Gray
//   rptr_bin        - binary decode of rptr_conv (combinational)
//   level           - registered (wptr - rptr_bin) mod 2^PTR_WIDTH
//   almost_full     - registered, high when level >= AFULL_THRESH
//   rptr_moved      - one-cycle pulse after each rptr_conv change
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fifo_wr_ptr_sync
  import fifo_wr_ptr_sync_pkg::*;
#(
  parameter int PTR_WIDTH    = DEF_PTR_WIDTH,
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [PTR_WIDTH-1:0] wptr,
  input  logic [PTR_WIDTH-1:0] rptr_gray_async,
  output logic [PTR_WIDTH-1:0] wptr_conv,
  output logic [PTR_WIDTH-1:0] rptr_conv,
  output logic [PTR_WIDTH-1:0] rptr_bin,
  output logic [PTR_WIDTH-1:0] level,
  output logic                 almost_full,
  output logic                 rptr_moved
);

  localparam logic [PTR_WIDTH-1:0] AFULL_P = PTR_WIDTH'(AFULL_THRESH);

  logic [PTR_WIDTH-1:0] w_rptr_sync;
  logic [PTR_WIDTH-1:0] w_wptr_gray;
  logic [PTR_WIDTH-1:0] w_level_nxt;

  logic [PTR_WIDTH-1:0] r_wptr_gray_p1;
  logic [PTR_WIDTH-1:0] r_level_p1;
  logic                 r_afull_p1;
  logic [PTR_WIDTH-1:0] r_rptr_prev_p1;
  logic                 r_moved_p1;

  bit_sync #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (NUM_STAGES)
  ) u_rptr_sync (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_d     (rptr_gray_async),
    .o_q     (w_rptr_sync)
  );

  // Stage 0: combinational encode/decode and modulo distance; wrap-around
  // falls out of the natural PTR_WIDTH-bit subtraction.
  assign w_wptr_gray = PTR_WIDTH'(bin2gray(PTR_MAX_W'(wptr)));
  assign rptr_bin    = PTR_WIDTH'(gray2bin(PTR_MAX_W'(w_rptr_sync)));
  assign w_level_nxt = wptr - rptr_bin;

  // Stage 1: registered outputs. almost_full is derived from the same next
  // level value so the flag and the level update on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr_gray_p1 <= '0;
      r_level_p1     <= '0;
      r_afull_p1     <= 1'b0;
      r_rptr_prev_p1 <= '0;
      r_moved_p1     <= 1'b0;
    end else begin
      r_wptr_gray_p1 <= w_wptr_gray;
      r_level_p1     <= w_level_nxt;
      r_afull_p1     <= (w_level_nxt >= AFULL_P);
      r_rptr_prev_p1 <= w_rptr_sync;
      r_moved_p1     <= (w_rptr_sync != r_rptr_prev_p1);
    end
  end

  assign wptr_conv   = r_wptr_gray_p1;
  assign rptr_conv   = w_rptr_sync;
  assign level       = r_level_p1;
  assign almost_full = r_afull_p1;
  assign rptr_moved  = r_moved_p1;

endmodule

// File: tb/tb_fifo_wr_ptr_sync.sv
`timescale 1ns/1ps
module tb_fifo_wr_ptr_sync;

  localparam int W = 4;

  typedef struct {
    int          due;
    int          sig;
    logic [W-1:0] val;
    string       tag;
  } exp_t;

  localparam int S_WGRAY = 0;
  localparam int S_RCONV = 1;
  localparam int S_RBIN  = 2;
  localparam int S_LEVEL = 3;
  localparam int S_AFULL = 4;
  localparam int S_MOVED = 5;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] wptr = '0;
  logic [W-1:0] rptr_gray_async = '0;
  logic [W-1:0] wptr_conv, rptr_conv, rptr_bin, level;
  logic         almost_full, rptr_moved;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic [W-1:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  fifo_wr_ptr_sync #(
    .PTR_WIDTH    (4),
    .NUM_STAGES   (2),
    .AFULL_THRESH (6)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .wptr            (wptr),
    .rptr_gray_async (rptr_gray_async),
    .wptr_conv       (wptr_conv),
    .rptr_conv       (rptr_conv),
    .rptr_bin        (rptr_bin),
    .level           (level),
    .almost_full     (almost_full),
    .rptr_moved      (rptr_moved)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] obs(input int sig);
    case (sig)
      S_WGRAY: return wptr_conv;
      S_RCONV: return rptr_conv;
      S_RBIN:  return rptr_bin;
      S_LEVEL: return level;
      S_AFULL: return {3'b000, almost_full};
      default: return {3'b000, rptr_moved};
    endcase
  endfunction

  task automatic expect_at(input int off, input int sig, input logic [W-1:0] v, input string tag);
    exp_t e;
    e.due = cyc + off;
    e.sig = sig;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input int off, input string tag);
    for (int s = 0; s < 6; s++) expect_at(off, s, '0, tag);
  endtask

  // Advance one edge, then compare every scoreboard entry due on it.
  task automatic tick();
    logic [W-1:0] o;
    @(posedge CLK);
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        o = obs(sb[i].sig);
        total++;
        assert (o === sb[i].val) else begin
          bad++;
          $error("FAIL %s sig=%0d cyc=%0d observed=%h expected=%h",
                 sb[i].tag, sb[i].sig, cyc, o, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int c;

    // Reset held with random inputs: every output must stay zero.
    for (int k = 0; k < 5; k++) begin
      wptr            = W'($urandom);
      rptr_gray_async = W'($urandom);
      expect_all_zero(1, "rst_hold");
      tick();
    end
    wptr            = '0;
    rptr_gray_async = '0;
    expect_all_zero(1, "rst_hold_last");
    tick();
    RST = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expect_at(k, S_MOVED, '0, "rst_release_no_pulse");
      expect_at(k, S_RCONV, '0, "rst_release_rconv");
    end
    ticks(4);

    // Gray encode sweep with read pointer at zero.
    for (int i = 0; i < 16; i++) begin
      wptr = W'(i);
      expect_at(1, S_WGRAY, gray_tbl[i], "gray_enc");
      expect_at(1, S_LEVEL, W'(i), "gray_level");
      expect_at(1, S_AFULL, (i >= 6) ? 4'd1 : 4'd0, "gray_afull");
      tick();
    end

    // Latency: step the async read pointer 0 -> Gray 3 (binary 2).
    wptr = 4'd2;
    ticks(3);
    rptr_gray_async = 4'b0011;
    expect_at(1, S_RCONV, 4'd0, "lat_rconv_early");
    expect_at(2, S_RCONV, 4'd3, "lat_rconv");
    expect_at(2, S_RBIN,  4'd2, "lat_rbin");
    expect_at(2, S_MOVED, 4'd0, "lat_moved_before");
    expect_at(3, S_MOVED, 4'd1, "lat_moved_pulse");
    expect_at(4, S_MOVED, 4'd0, "lat_moved_after");
    expect_at(3, S_LEVEL, 4'd0, "lat_level");
    ticks(5);

    // Wrap: wptr=1 against synced read pointer binary 15 -> level 2.
    wptr            = 4'd1;
    rptr_gray_async = 4'b1000;
    expect_at(2, S_RBIN,  4'd15, "wrap_rbin");
    expect_at(3, S_LEVEL, 4'd2,  "wrap_level");
    expect_at(3, S_AFULL, 4'd0,  "wrap_afull");
    ticks(4);
    wptr            = 4'd7;
    rptr_gray_async = 4'd0;
    expect_at(3, S_LEVEL, 4'd7, "lvl7_level");
    expect_at(3, S_AFULL, 4'd1, "lvl7_afull");
    ticks(4);

    // Simultaneous change: wptr 5->6 lands with rptr_bin 2->3.
    wptr            = 4'd5;
    rptr_gray_async = gray_tbl[2];
    ticks(4);
    rptr_gray_async = gray_tbl[3];
    for (int k = 1; k <= 5; k++) expect_at(k, S_LEVEL, 4'd3, "simul_level");
    expect_at(2, S_RBIN, 4'd3, "simul_rbin");
    ticks(2);
    wptr = 4'd6;
    ticks(3);

    // Mid-operation reset while a new value sits in the chain.
    rptr_gray_async = 4'd0;
    ticks(4);
    rptr_gray_async = 4'd5;
    tick();
    RST = 1'b0;
    expect_all_zero(1, "midrst_clear");
    tick();
    RST = 1'b1;
    c = cyc;
    expect_at(1, S_RCONV, 4'd0, "midrst_rconv_early");
    expect_at(2, S_RCONV, 4'd5, "midrst_rconv");
    expect_at(3, S_MOVED, 4'd1, "midrst_moved");
    ticks(4);

    // Drain anything left; leftovers are failures.
    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s never compared (due cyc %0d, now %0d, start %0d)",
               sb[0].tag, sb[0].due, cyc, c);
      void'(sb.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
